// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor computing diff = a - b, LSB first,
//   one bit per clock through a single full-subtract cell and a borrow flop.
//   A start accepted in IDLE captures the operands. WIDTH SHIFT cycles
//   follow, then a one-cycle done pulse in DONE. diff and borrow_out
//   update only on entry to DONE and are held until the next completion.
//
//   Optional build macro: SERIAL_SUBTRACTOR_OVERFLOW_EN
//     When defined, adds the registered signed-overflow flag 'overflow'.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   request, sampled only in IDLE
//   a, b       in   minuend / subtrahend, captured on accepted start
//   busy       out  high while in SHIFT
//   done       out  one-cycle pulse, result valid
//   diff       out  a - b modulo 2^WIDTH
//   borrow_out out  final borrow (unsigned a < b)
//   overflow   out  signed overflow (only with SERIAL_SUBTRACTOR_OVERFLOW_EN)
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic busy_nxt;
  logic done_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Only WIDTH-1 bits are stored; the current bit completes the word.
  logic [WIDTH-2:0] diff_sh;
  logic             br;
  logic [CW-1:0]    count;

  logic             ai;
  logic             bi;
  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] diff_full;
  logic             last_bit;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic a_msb;
  logic b_msb;
`endif

  // Full-subtract cell on the current LSBs.
  always_comb begin
    ai        = a_sh[0];
    bi        = b_sh[0];
    d         = ai ^ bi ^ br;
    br_nxt    = (~ai & bi) | (~(ai ^ bi) & br);
    diff_full = {d, diff_sh};
    last_bit  = (count == LAST);
  end

  // State register; busy/done are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode of the upcoming state.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      S_SHIFT: busy_nxt = 1'b1;
      S_DONE:  done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Operand shift registers, borrow flop, bit counter and held results.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh       <= '0;
      b_sh       <= '0;
      diff_sh    <= '0;
      br         <= 1'b0;
      count      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            diff_sh <= '0;
            br      <= 1'b0;
            count   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            a_msb   <= a[WIDTH-1];
            b_msb   <= b[WIDTH-1];
`endif
          end
        end
        S_SHIFT: begin
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          diff_sh <= diff_full[WIDTH-1:1];
          br      <= br_nxt;
          count   <= count + CW'(1);
          if (last_bit) begin
            diff       <= diff_full;
            borrow_out <= br_nxt;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            // Signed overflow: operand signs differ and result sign differs from a.
            overflow   <= (a_msb != b_msb) && (diff_full[WIDTH-1] != a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=16
//   against an arithmetic reference: {borrow, diff} = {0,a} - {0,b}.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, borrow8;
  logic [7:0]  diff8;
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        busy16, done16, borrow16;
  logic [15:0] diff16;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic        ovf8, ovf16;
`endif

  int checks = 0;
  int errors = 0;
  bit sel16  = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    , .overflow(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(borrow16)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    , .overflow(ovf16)
`endif
  );

  // Observation mux for whichever instance is under test.
  logic        busy_s, done_s, borrow_s;
  logic [15:0] diff_s;
  assign busy_s   = sel16 ? busy16   : busy8;
  assign done_s   = sel16 ? done16   : done8;
  assign borrow_s = sel16 ? borrow16 : borrow8;
  assign diff_s   = sel16 ? diff16   : {8'h00, diff8};
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic ovf_s;
  assign ovf_s = sel16 ? ovf16 : ovf8;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit v);
    if (sel16) start16 = v; else start8 = v;
  endtask

  task automatic set_ops(input logic [15:0] av, input logic [15:0] bv);
    if (sel16) begin a16 = av; b16 = bv; end
    else begin a8 = av[7:0]; b8 = bv[7:0]; end
  endtask

  // Wait (bounded) for done; report cycles and busy cycles seen.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!done_s && cyc < 64) begin
      if (busy_s) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  // Reference results from plain arithmetic.
  task automatic model(input logic [15:0] av, input logic [15:0] bv,
                       output logic [15:0] ed, output logic eb, output logic eo);
    logic [16:0] full;
    int sa, sb, r;
    if (sel16) begin
      full = {1'b0, av} - {1'b0, bv};
      sa = int'($signed(av)); sb = int'($signed(bv));
      r  = sa - sb;
      eo = (r > 32767) || (r < -32768);
      ed = full[15:0];
      eb = full[16];
    end else begin
      full = {9'h0, av[7:0]} - {9'h0, bv[7:0]};
      sa = int'($signed(av[7:0])); sb = int'($signed(bv[7:0]));
      r  = sa - sb;
      eo = (r > 127) || (r < -128);
      ed = {8'h00, full[7:0]};
      eb = full[8];
    end
  endtask

  // One full operation; entered and left at a negedge, back-to-back capable.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv);
    logic [15:0] ed;
    logic eb, eo;
    int cyc, bcnt, w;
    w = sel16 ? 16 : 8;
    model(av, bv, ed, eb, eo);
    set_start(1'b1);
    set_ops(av, bv);
    @(negedge clk);
    set_start(1'b0);
    set_ops(16'($urandom), 16'($urandom));
    wait_done(cyc, bcnt);
    check({tag, "_latency"}, 32'(cyc), 32'(w));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(w));
    check({tag, "_done"}, 32'(done_s), 32'd1);
    check({tag, "_diff"}, 32'(diff_s), 32'(ed));
    check({tag, "_borrow"}, 32'(borrow_s), 32'(eb));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    check({tag, "_overflow"}, 32'(ovf_s), 32'(eo));
`endif
    @(negedge clk);
    check({tag, "_done_single"}, 32'(done_s), 32'd0);
    check({tag, "_diff_held"}, 32'(diff_s), 32'(ed));
  endtask

  initial begin
    logic [15:0] ed;
    logic eb, eo;
    int cyc, bcnt;
    bit saw_done;

    // Reset state.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_borrow", 32'(borrow8), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    check("rst_overflow", 32'(ovf8), 32'd0);
`endif

    // Directed 8-bit operations.
    sel16 = 1'b0;
    run_op("d_05_03", 16'h05, 16'h03);
    run_op("d_03_05", 16'h03, 16'h05);
    run_op("d_00_ff", 16'h00, 16'hFF);
    run_op("d_00_00", 16'h00, 16'h00);
    run_op("d_80_01", 16'h80, 16'h01);
    run_op("d_7f_ff", 16'h7F, 16'hFF);
    run_op("d_ff_00", 16'hFF, 16'h00);

    // Start held high with operands changing after accept.
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h11;
    wait_done(cyc, bcnt);
    check("hold_first_done", 32'(done8), 32'd1);
    check("hold_first_diff", 32'(diff8), 32'h0F);
    @(negedge clk);
    check("hold_idle_busy", 32'(busy8), 32'd0);
    check("hold_idle_done", 32'(done8), 32'd0);
    @(negedge clk);
    check("hold_second_busy", 32'(busy8), 32'd1);
    check("hold_diff_stable", 32'(diff8), 32'h0F);
    wait_done(cyc, bcnt);
    start8 = 1'b0;
    check("hold_second_done", 32'(done8), 32'd1);
    check("hold_second_diff", 32'(diff8), 32'h99);
    check("hold_second_borrow", 32'(borrow8), 32'd0);
    @(negedge clk);

    // Reset in the middle of SHIFT discards the partial result.
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h22;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_before", 32'(busy8), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy8), 32'd0);
    check("mid_rst_done", 32'(done8), 32'd0);
    check("mid_rst_diff", 32'(diff8), 32'd0);
    check("mid_rst_borrow", 32'(borrow8), 32'd0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1'b1;
    end
    check("mid_rst_no_done", 32'(saw_done), 32'd0);
    run_op("post_rst_20_10", 16'h20, 16'h10);

    // Random back-to-back runs at both widths.
    sel16 = 1'b0;
    for (int i = 0; i < 500; i++) run_op("rnd8", 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
    sel16 = 1'b1;
    run_op("d16_0000_ffff", 16'h0000, 16'hFFFF);
    run_op("d16_8000_0001", 16'h8000, 16'h0001);
    for (int i = 0; i < 500; i++) run_op("rnd16", 16'($urandom), 16'($urandom));

    // Keep the unused model outputs referenced for the default build.
    model(16'h0, 16'h0, ed, eb, eo);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
